// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: opcode values and FSM states.
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MADD  = 3'd4;
    localparam logic [2:0] MDU_MADDU = 3'd5;
    localparam logic [2:0] MDU_MSUB  = 3'd6;
    localparam logic [2:0] MDU_MSUBU = 3'd7;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } mdu_state_t;

endpackage

// File: rtl/mdu_calc.sv
// Combinational result datapath: next HI/LO for an op given the current HI/LO.
module mdu_calc
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_hi,
    input  logic [WIDTH-1:0] i_lo,
    output logic [WIDTH-1:0] o_hi_n,
    output logic [WIDTH-1:0] o_lo_n
);

    localparam int W2 = 2 * WIDTH;

    logic signed [W2-1:0]    w_sa;
    logic signed [W2-1:0]    w_sb;
    logic signed [W2-1:0]    w_sprod;
    logic [W2-1:0]           w_uprod;
    logic [W2-1:0]           w_prod;
    logic [W2-1:0]           w_acc;
    logic [W2-1:0]           w_res;
    logic [WIDTH-1:0]        w_sq;
    logic [WIDTH-1:0]        w_sr;
    logic [WIDTH-1:0]        w_uq;
    logic [WIDTH-1:0]        w_ur;
    logic                    w_b_zero;
    logic                    w_div_ovf;

    assign w_sa    = {{WIDTH{i_a[WIDTH-1]}}, i_a};
    assign w_sb    = {{WIDTH{i_b[WIDTH-1]}}, i_b};
    assign w_sprod = w_sa * w_sb;
    assign w_uprod = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};
    // op[0] selects the unsigned flavour for every multiply-class opcode
    assign w_prod  = i_op[0] ? w_uprod : w_sprod;
    assign w_acc   = {i_hi, i_lo};

    assign w_b_zero  = (i_b == '0);
    // MIN / -1 overflows the quotient; architecturally LO=MIN, HI=0
    assign w_div_ovf = (i_a == {1'b1, {(WIDTH-1){1'b0}}}) && (i_b == '1);
    assign w_sq      = $signed(i_a) / $signed(i_b);
    assign w_sr      = $signed(i_a) % $signed(i_b);
    assign w_uq      = i_a / i_b;
    assign w_ur      = i_a % i_b;

    always_comb begin
        w_res = w_acc;
        case (i_op)
            MDU_MULT, MDU_MULTU: w_res = w_prod;
            MDU_MADD, MDU_MADDU: w_res = w_acc + w_prod;
            MDU_MSUB, MDU_MSUBU: w_res = w_acc - w_prod;
            MDU_DIV: begin
                if (w_div_ovf)      w_res = {{WIDTH{1'b0}}, i_a};
                else if (!w_b_zero) w_res = {w_sr, w_sq};
            end
            MDU_DIVU: begin
                if (!w_b_zero) w_res = {w_ur, w_uq};
            end
            default: w_res = w_acc;
        endcase
    end

    assign o_hi_n = w_res[W2-1:WIDTH];
    assign o_lo_n = w_res[WIDTH-1:0];

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with HI/LO; result is computed at start
// and released to HI/LO after the op's configured latency.
// state  | meaning
// S_IDLE | accepts start or MTHI/MTLO
// S_RUN  | counting down latency, temporaries hold the pending result
module mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mt_hi,
    input  logic             mt_lo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] C_MULT = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] C_DIV  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    mdu_state_t       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi_n;
    logic [WIDTH-1:0] r_lo_n;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] w_hi_n;
    logic [WIDTH-1:0] w_lo_n;
    logic             w_is_div;

    assign w_is_div = (op == MDU_DIV) || (op == MDU_DIVU);

    mdu_calc #(.WIDTH(WIDTH)) u_calc (
        .i_op   (op),
        .i_a    (a),
        .i_b    (b),
        .i_hi   (r_hi),
        .i_lo   (r_lo),
        .o_hi_n (w_hi_n),
        .o_lo_n (w_lo_n)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_hi_n  <= '0;
            r_lo_n  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_hi_n  <= w_hi_n;
                        r_lo_n  <= w_lo_n;
                        r_cnt   <= w_is_div ? C_DIV : C_MULT;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        if (mt_hi) r_hi <= a;
                        if (mt_lo) r_lo <= a;
                    end
                end
                S_RUN: begin
                    if (r_cnt == C_ONE) begin
                        r_hi    <= r_hi_n;
                        r_lo    <= r_lo_n;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - C_ONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: a default-latency instance and a single-cycle instance,
// with expected HI/LO queued at issue and checked on each done pulse.
module tb_mdu;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start0 = 1'b0, start1 = 1'b0;
    logic        mt_hi = 1'b0, mt_lo = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0, b = '0;
    logic        busy0, done0, busy1, done1;
    logic [31:0] hi0, lo0, hi1, lo1;

    int          vectors = 0;
    int          errs = 0;
    int          done_cnt0 = 0, done_cnt1 = 0;
    logic [63:0] q0[$];
    logic [63:0] q1[$];
    logic [63:0] m0 = '0, m1 = '0;
    logic [63:0] e0, e1;

    always #5 clk = ~clk;

    mdu #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut0 (
        .clk(clk), .reset(rst_n), .start(start0), .op(op), .a(a), .b(b),
        .mt_hi(mt_hi), .mt_lo(mt_lo), .busy(busy0), .done(done0), .hi(hi0), .lo(lo0)
    );

    mdu #(.WIDTH(32), .MULT_CYCLES(1), .DIV_CYCLES(1)) dut1 (
        .clk(clk), .reset(rst_n), .start(start1), .op(op), .a(a), .b(b),
        .mt_hi(1'b0), .mt_lo(1'b0), .busy(busy1), .done(done1), .hi(hi1), .lo(lo1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x,
                                          input logic [31:0] y, input logic [63:0] acc);
        longint          sx, sy, q, r;
        longint unsigned ux, uy, uq, ur;
        logic [63:0]     ps, pu;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        ps = sx * sy;
        pu = ux * uy;
        model = acc;
        case (o)
            MDU_MULT:  model = ps;
            MDU_MULTU: model = pu;
            MDU_MADD:  model = acc + ps;
            MDU_MADDU: model = acc + pu;
            MDU_MSUB:  model = acc - ps;
            MDU_MSUBU: model = acc - pu;
            MDU_DIV: if (y != 0) begin
                q = sx / sy;
                r = sx % sy;
                model = {r[31:0], q[31:0]};
            end
            MDU_DIVU: if (y != 0) begin
                uq = ux / uy;
                ur = ux % uy;
                model = {ur[31:0], uq[31:0]};
            end
            default: model = acc;
        endcase
    endfunction

    always @(negedge clk) begin
        if (done0) begin
            done_cnt0++;
            if (q0.size() == 0) chk("done0_spurious", 64'd1, 64'd0);
            else begin
                e0 = q0.pop_front();
                chk("hilo0", {hi0, lo0}, e0);
            end
        end
        if (done1) begin
            done_cnt1++;
            if (q1.size() == 0) chk("done1_spurious", 64'd1, 64'd0);
            else begin
                e1 = q1.pop_front();
                chk("hilo1", {hi1, lo1}, e1);
            end
        end
    end

    task automatic set_start(input bit d1, input logic v);
        if (d1) start1 = v;
        else    start0 = v;
    endtask

    task automatic count_busy(input bit d1, output int cyc);
        cyc = 0;
        while ((d1 ? busy1 : busy0) && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input bit d1, input logic [2:0] o, input logic [31:0] aa,
                          input logic [31:0] bb, input logic [63:0] exp, input int ncyc,
                          input bit disturb, input bit with_mthi, input string tag);
        int cyc;
        int dc;
        cyc = 0;
        if (d1) begin q1.push_back(exp); dc = done_cnt1; m1 = exp; end
        else    begin q0.push_back(exp); dc = done_cnt0; m0 = exp; end
        @(negedge clk);
        op = o; a = aa; b = bb; mt_hi = with_mthi;
        set_start(d1, 1'b1);
        @(negedge clk);
        set_start(d1, 1'b0);
        mt_hi = 1'b0;
        while ((d1 ? busy1 : busy0) && cyc < 100) begin
            cyc++;
            if (disturb && cyc == 1) begin
                start0 = 1'b1; op = MDU_DIV; a = 32'hDEAD_0000; b = 32'd7; mt_lo = 1'b1;
            end else begin
                start0 = 1'b0; mt_lo = 1'b0;
            end
            @(negedge clk);
        end
        start0 = 1'b0;
        mt_lo = 1'b0;
        chk({tag, "_cycles"}, 64'(cyc), 64'(ncyc));
        @(negedge clk);
        chk({tag, "_done"}, 64'((d1 ? done_cnt1 : done_cnt0) - dc), 64'd1);
    endtask

    task automatic b2b(input bit d1, input logic [31:0] a1, input logic [31:0] b1,
                       input logic [31:0] a2, input logic [31:0] b2, input int n,
                       input string tag);
        logic [63:0] x1, x2;
        int cyc;
        int dc;
        x1 = model(MDU_MULT, a1, b1, d1 ? m1 : m0);
        x2 = model(MDU_MULT, a2, b2, x1);
        if (d1) begin q1.push_back(x1); q1.push_back(x2); dc = done_cnt1; m1 = x2; end
        else    begin q0.push_back(x1); q0.push_back(x2); dc = done_cnt0; m0 = x2; end
        @(negedge clk);
        op = MDU_MULT; a = a1; b = b1;
        set_start(d1, 1'b1);
        @(negedge clk);
        set_start(d1, 1'b0);
        count_busy(d1, cyc);
        chk({tag, "_cycles1"}, 64'(cyc), 64'(n));
        a = a2; b = b2;
        set_start(d1, 1'b1);
        @(negedge clk);
        set_start(d1, 1'b0);
        chk({tag, "_rebusy"}, 64'(d1 ? busy1 : busy0), 64'd1);
        count_busy(d1, cyc);
        chk({tag, "_cycles2"}, 64'(cyc), 64'(n));
        @(negedge clk);
        chk({tag, "_done"}, 64'((d1 ? done_cnt1 : done_cnt0) - dc), 64'd2);
    endtask

    task automatic do_mt(input bit h, input bit l, input logic [31:0] v);
        @(negedge clk);
        mt_hi = h; mt_lo = l; a = v;
        @(negedge clk);
        mt_hi = 1'b0; mt_lo = 1'b0;
        if (h) m0[63:32] = v;
        if (l) m0[31:0] = v;
    endtask

    logic [2:0] rops[6];
    logic [31:0] ra, rb;
    logic [63:0] rexp;
    int dc_rst;

    initial begin
        rops = '{MDU_MULT, MDU_DIV, MDU_MADD, MDU_MSUB, MDU_DIVU, MDU_MADDU};
        repeat (2) @(negedge clk);
        chk("rst_dut0", {30'd0, busy0, done0, hi0, lo0}, 64'd0);
        chk("rst_dut1", {30'd0, busy1, done1, hi1, lo1}, 64'd0);
        rst_n = 1'b1;

        do_mt(1'b1, 1'b0, 32'h55);
        do_mt(1'b0, 1'b1, 32'h66);
        chk("mt_first", {hi0, lo0}, {32'h55, 32'h66});

        // asynchronous reset while an op is in flight
        @(negedge clk);
        op = MDU_MULT; a = 32'd3; b = 32'd4; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        @(negedge clk);
        chk("midop_busy", 64'(busy0), 64'd1);
        dc_rst = done_cnt0;
        #2 rst_n = 1'b0;
        #1 chk("midop_rst", {31'd0, busy0, hi0, lo0}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("midop_nodone", 64'(done_cnt0 - dc_rst), 64'd0);
        m0 = '0;

        run_op(0, MDU_MULT,  32'hFFFF_FFFF, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFE}, 5, 0, 0, "mult");
        run_op(0, MDU_MULTU, 32'hFFFF_FFFF, 32'd2, {32'h0000_0001, 32'hFFFF_FFFE}, 5, 0, 0, "multu");
        run_op(0, MDU_DIV,   32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 10, 0, 0, "div");
        run_op(0, MDU_DIVU,  32'd7,         32'd0, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 10, 0, 0, "divu_zero");

        do_mt(1'b1, 1'b0, 32'd5);
        do_mt(1'b0, 1'b1, 32'd3);
        chk("mt_pair", {hi0, lo0}, {32'd5, 32'd3});
        run_op(0, MDU_MADD,  32'd2, 32'd4,  {32'd5, 32'd11}, 5, 0, 0, "madd");
        run_op(0, MDU_MSUBU, 32'd1, 32'd12, {32'd4, 32'hFFFF_FFFF}, 5, 0, 0, "msubu");

        run_op(0, MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 10, 0, 0, "div_ovf");
        run_op(0, MDU_MULT,  32'd3, 32'd4, {32'd0, 32'd12}, 5, 1, 0, "ignore_run");
        run_op(0, MDU_MULTU, 32'd6, 32'd7, {32'd0, 32'd42}, 5, 0, 1, "start_mthi");

        do_mt(1'b1, 1'b1, 32'hA5A5_0001);
        chk("mt_both", {hi0, lo0}, {32'hA5A5_0001, 32'hA5A5_0001});

        b2b(0, 32'hFFFF_FFFD, 32'd5, 32'h0001_2345, 32'h100, 5, "b2b0");

        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom;
            rexp = model(rops[i], ra, rb, m0);
            run_op(0, rops[i], ra, rb, rexp,
                   (rops[i] == MDU_DIV || rops[i] == MDU_DIVU) ? 10 : 5, 0, 0, "rand");
        end

        run_op(1, MDU_MULT, 32'hFFFF_FFFF, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFE}, 1, 0, 0, "mult_c1");
        b2b(1, 32'hFFFF_FFFD, 32'd5, 32'h0001_2345, 32'h100, 1, "b2b1");
        run_op(1, MDU_DIV, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1, 0, 0, "div_c1");

        repeat (3) @(negedge clk);
        chk("queues_drained", 64'(q0.size() + q1.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
